// File: rtl/serial_code_converter.sv
// Serial Excess-3 <-> BCD converter, LSB-first, 4 bits per digit, Mealy output.
// Define SERIAL_CONV_ERRCHK_EN to enable per-digit input range checking (Err).
module serial_code_converter #(
    parameter int NDIGITS = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    input  logic En,
    input  logic Mode,
    output logic Z,
    output logic DigitDone,
    output logic WordDone,
    output logic Err
);

    localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NDIGITS - 1);
    localparam logic [3:0] K = 4'b0011;

    localparam logic [1:0] BIT0 = 2'd0;
    localparam logic [1:0] BIT3 = 2'd3;

    logic [1:0]    bit_idx;
    logic [DW-1:0] digit_idx;
    logic          carry;
    logic          mode_q;

    logic first_bit;
    logic last_bit;
    logic last_digit;
    logic k_bit;
    logic c_eff;
    logic mode_eff;
    logic z_raw;
    logic c_next;

    // Carry/borrow never crosses a digit boundary; mode is sampled live on bit 0.
    always_comb begin
        first_bit  = (bit_idx == BIT0);
        last_bit   = (bit_idx == BIT3);
        last_digit = (digit_idx == LAST_DIGIT);
        k_bit      = K[bit_idx];
        c_eff      = first_bit ? 1'b0 : carry;
        mode_eff   = first_bit ? Mode : mode_q;
        z_raw      = X ^ k_bit ^ c_eff;
        if (mode_eff)
            c_next = (X & k_bit) | (X & c_eff) | (k_bit & c_eff);
        else
            c_next = (~X & (k_bit | c_eff)) | (k_bit & c_eff);
        Z = En & ~Rst & z_raw;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bit_idx   <= BIT0;
            digit_idx <= '0;
            carry     <= 1'b0;
            mode_q    <= 1'b0;
            DigitDone <= 1'b0;
            WordDone  <= 1'b0;
        end else begin
            DigitDone <= 1'b0;
            WordDone  <= 1'b0;
            if (En) begin
                carry   <= c_next;
                bit_idx <= bit_idx + 2'd1;
                if (first_bit)
                    mode_q <= Mode;
                if (last_bit) begin
                    DigitDone <= 1'b1;
                    if (last_digit) begin
                        WordDone  <= 1'b1;
                        digit_idx <= '0;
                    end else begin
                        digit_idx <= digit_idx + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SERIAL_CONV_ERRCHK_EN
    logic [2:0] shreg;
    logic [3:0] digit_val;
    logic       out_of_range;

    // Bit 3 is never bit 0, so the latched mode applies to the range test.
    always_comb begin
        digit_val = {X, shreg};
        if (mode_q)
            out_of_range = (digit_val > 4'd9);
        else
            out_of_range = (digit_val < 4'd3) || (digit_val > 4'd12);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shreg <= '0;
            Err   <= 1'b0;
        end else if (En) begin
            shreg <= {X, shreg[2:1]};
            if (first_bit && (digit_idx == '0))
                Err <= 1'b0;
            else if (last_bit && out_of_range)
                Err <= 1'b1;
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule
